// File: rtl/image_xform_if.sv
// Controller / image-RAM bus of the image transform engine.
// The engine connects through the slave modport; the controller and the
// image RAMs (or a bench standing in for them) use the master modport.
interface image_xform_if #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CH_W  = 8
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int PW = 3 * CH_W;

  logic          start;
  logic [1:0]    mode;
  logic [PW-1:0] pixel_in;
  logic [RW-1:0] row_sel;
  logic [CW-1:0] col_sel;
  logic          write_enable;
  logic [PW-1:0] pixel_out;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, pixel_in,
    input  row_sel, col_sel, write_enable, pixel_out, busy, done
  );

  modport slave (
    input  start, mode, pixel_in,
    output row_sel, col_sel, write_enable, pixel_out, busy, done
  );
endinterface

// File: rtl/image_xform_engine.sv
// Image transform engine: vertical mirror, horizontal mirror, grayscale,
// or vertical mirror plus grayscale over an IMG_H x IMG_W image.
// The source is read through a 1-cycle-latency port and the destination is
// written through the same row/col address pair plus write_enable.
module image_xform_engine #(
  parameter int IMG_W          = 64,
  parameter int IMG_H          = 64,
  parameter int CH_W           = 8,
  parameter int GRAY_REPLICATE = 0
) (
  input logic          clk,
  input logic          rst_n,
  image_xform_if.slave xf
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int PW = 3 * CH_W;

  localparam logic [RW-1:0] R_MAX  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_HALF = RW'(IMG_H / 2 - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_HALF = CW'(IMG_W / 2 - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  localparam logic [1:0] MODE_V  = 2'b00;
  localparam logic [1:0] MODE_H  = 2'b01;
  localparam logic [1:0] MODE_G  = 2'b10;
  localparam logic [1:0] MODE_VG = 2'b11;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_A  = 4'd1,
    RD_B  = 4'd2,
    CAP_B = 4'd3,
    CMP   = 4'd4,
    WR_1  = 4'd5,
    WR_2  = 4'd6,
    G_RD  = 4'd7,
    G_CAP = 4'd8,
    G_CMP = 4'd9,
    G_WR  = 4'd10,
    FIN   = 4'd11
  } state_t;

  state_t        state_r;
  logic [1:0]    mode_r;
  logic [RW-1:0] r_r;
  logic [CW-1:0] c_r;
  logic [PW-1:0] a_r;
  logic [PW-1:0] b_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] col_r;
  logic          we_r;
  logic [PW-1:0] pix_out_r;
  logic          busy_r;
  logic          done_r;

  logic [RW-1:0] part_row_s;
  logic [CW-1:0] part_col_s;
  logic [RW-1:0] r_last_s;
  logic [CW-1:0] c_last_s;
  logic          col_wrap_s;
  logic          last_s;
  logic [RW-1:0] r_nxt_s;
  logic [CW-1:0] c_nxt_s;

  // Gray value of a pixel: average of the largest and smallest channel.
  // The sum is one bit wider than a channel so it cannot overflow; the
  // halving simply drops the low bit.
  function automatic logic [PW-1:0] gray_pix(input logic [PW-1:0] p);
    logic [CH_W-1:0] ch_r;
    logic [CH_W-1:0] ch_g;
    logic [CH_W-1:0] ch_b;
    logic [CH_W-1:0] mn;
    logic [CH_W-1:0] mx;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] avg;
    ch_r = p[PW-1:2*CH_W];
    ch_g = p[2*CH_W-1:CH_W];
    ch_b = p[CH_W-1:0];
    mn   = (ch_g < ch_r) ? ch_g : ch_r;
    mn   = (ch_b < mn)   ? ch_b : mn;
    mx   = (ch_g > ch_r) ? ch_g : ch_r;
    mx   = (ch_b > mx)   ? ch_b : mx;
    sum  = {1'b0, mx} + {1'b0, mn};
    avg  = sum[CH_W:1];
    if (GRAY_REPLICATE != 0) begin
      gray_pix = {avg, avg, avg};
    end else begin
      gray_pix = {{CH_W{1'b0}}, avg, {CH_W{1'b0}}};
    end
  endfunction

  // Mirror partner address, iteration limits and next counter value.
  always_comb begin
    part_row_s = r_r;
    part_col_s = c_r;
    r_last_s   = R_MAX;
    c_last_s   = C_MAX;
    case (mode_r)
      MODE_V, MODE_VG: begin
        part_row_s = R_MAX - r_r;
        r_last_s   = R_HALF;
      end
      MODE_H: begin
        part_col_s = C_MAX - c_r;
        c_last_s   = C_HALF;
      end
      MODE_G: begin
        part_row_s = r_r;
        part_col_s = c_r;
      end
      default: begin
        part_row_s = r_r;
        part_col_s = c_r;
      end
    endcase
    // End is detected on the last index so non-power-of-2 sizes work.
    col_wrap_s = (c_r == c_last_s);
    last_s     = col_wrap_s && (r_r == r_last_s);
    if (col_wrap_s) begin
      c_nxt_s = {CW{1'b0}};
      r_nxt_s = r_r + R_ONE;
    end else begin
      c_nxt_s = c_r + C_ONE;
      r_nxt_s = r_r;
    end
  end

  // Control FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mode_r    <= 2'b00;
      r_r       <= {RW{1'b0}};
      c_r       <= {CW{1'b0}};
      a_r       <= {PW{1'b0}};
      b_r       <= {PW{1'b0}};
      row_r     <= {RW{1'b0}};
      col_r     <= {CW{1'b0}};
      we_r      <= 1'b0;
      pix_out_r <= {PW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          we_r <= 1'b0;
          if (xf.start) begin
            mode_r  <= xf.mode;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            r_r     <= {RW{1'b0}};
            c_r     <= {CW{1'b0}};
            row_r   <= {RW{1'b0}};
            col_r   <= {CW{1'b0}};
            state_r <= (xf.mode == MODE_G) ? G_RD : RD_A;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_A: begin
          // Address of A is on the bus this cycle; move on to the partner.
          row_r   <= part_row_s;
          col_r   <= part_col_s;
          state_r <= RD_B;
        end
        RD_B: begin
          a_r     <= xf.pixel_in;
          state_r <= CAP_B;
        end
        CAP_B: begin
          b_r <= xf.pixel_in;
          if (mode_r == MODE_VG) begin
            state_r <= CMP;
          end else begin
            row_r     <= part_row_s;
            col_r     <= part_col_s;
            we_r      <= 1'b1;
            pix_out_r <= a_r;
            state_r   <= WR_1;
          end
        end
        CMP: begin
          a_r       <= gray_pix(a_r);
          b_r       <= gray_pix(b_r);
          row_r     <= part_row_s;
          col_r     <= part_col_s;
          we_r      <= 1'b1;
          pix_out_r <= gray_pix(a_r);
          state_r   <= WR_1;
        end
        WR_1: begin
          row_r     <= r_r;
          col_r     <= c_r;
          we_r      <= 1'b1;
          pix_out_r <= b_r;
          state_r   <= WR_2;
        end
        WR_2: begin
          we_r <= 1'b0;
          if (last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= FIN;
          end else begin
            r_r     <= r_nxt_s;
            c_r     <= c_nxt_s;
            row_r   <= r_nxt_s;
            col_r   <= c_nxt_s;
            state_r <= RD_A;
          end
        end
        G_RD: begin
          state_r <= G_CAP;
        end
        G_CAP: begin
          a_r     <= xf.pixel_in;
          state_r <= G_CMP;
        end
        G_CMP: begin
          we_r      <= 1'b1;
          pix_out_r <= gray_pix(a_r);
          state_r   <= G_WR;
        end
        G_WR: begin
          we_r <= 1'b0;
          if (last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= FIN;
          end else begin
            r_r     <= r_nxt_s;
            c_r     <= c_nxt_s;
            row_r   <= r_nxt_s;
            col_r   <= c_nxt_s;
            state_r <= G_RD;
          end
        end
        FIN: begin
          // A start seen here is deliberately not accepted.
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign xf.row_sel      = row_r;
  assign xf.col_sel      = col_r;
  assign xf.write_enable = we_r;
  assign xf.pixel_out    = pix_out_r;
  assign xf.busy         = busy_r;
  assign xf.done         = done_r;
endmodule

// File: tb/tb_image_xform_engine.sv
// Bench for image_xform_engine on a 4x4 image. A reference model derives
// the expected write sequence, final image and run length from the
// transform rules; a compare process checks every write cycle.
module tb_image_xform_engine;
  localparam int W = 4;
  localparam int H = 4;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;

  image_xform_if #(.IMG_W(W), .IMG_H(H), .CH_W(8)) if0 ();
  image_xform_if #(.IMG_W(W), .IMG_H(H), .CH_W(8)) if1 ();

  image_xform_engine #(.IMG_W(W), .IMG_H(H), .CH_W(8), .GRAY_REPLICATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .xf(if0)
  );
  image_xform_engine #(.IMG_W(W), .IMG_H(H), .CH_W(8), .GRAY_REPLICATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .xf(if1)
  );

  logic [23:0] src0 [H][W];
  logic [23:0] dst0 [H][W];
  logic [23:0] src1 [H][W];
  logic [23:0] dst1 [H][W];
  logic [23:0] exp_img [H][W];
  int          exp_cyc;

  typedef struct {
    int          r;
    int          c;
    logic [23:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Source RAMs (1-cycle read latency) and destination RAMs.
  always @(posedge clk) begin
    if0.pixel_in <= src0[if0.row_sel][if0.col_sel];
    if1.pixel_in <= src1[if1.row_sel][if1.col_sel];
    if (if0.write_enable) dst0[if0.row_sel][if0.col_sel] <= if0.pixel_out;
    if (if1.write_enable) dst1[if1.row_sel][if1.col_sel] <= if1.pixel_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] gray_m(input logic [23:0] p, input int rep);
    int r, g, b, mx, mn, avg;
    r = p[23:16];
    g = p[15:8];
    b = p[7:0];
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    avg = (mx + mn) / 2;
    return (rep != 0) ? {avg[7:0], avg[7:0], avg[7:0]} : {8'h00, avg[7:0], 8'h00};
  endfunction

  // Expected write order, final image and cycle count for one run on dut0.
  task automatic build_exp(input logic [1:0] m);
    wr_t w;
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (m)
          2'b00: exp_img[r][c] = src0[H-1-r][c];
          2'b01: exp_img[r][c] = src0[r][W-1-c];
          2'b10: exp_img[r][c] = gray_m(src0[r][c], 0);
          default: exp_img[r][c] = gray_m(src0[H-1-r][c], 0);
        endcase
    if (m == 2'b10) begin
      exp_cyc = H * W * 4;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          w.r = r; w.c = c; w.d = gray_m(src0[r][c], 0); exp_q.push_back(w);
        end
    end else if (m == 2'b01) begin
      exp_cyc = H * (W / 2) * 5;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W / 2; c++) begin
          w.r = r; w.c = W-1-c; w.d = src0[r][c];     exp_q.push_back(w);
          w.r = r; w.c = c;     w.d = src0[r][W-1-c]; exp_q.push_back(w);
        end
    end else begin
      exp_cyc = (H / 2) * W * ((m == 2'b11) ? 6 : 5);
      for (int r = 0; r < H / 2; r++)
        for (int c = 0; c < W; c++) begin
          w.r = H-1-r; w.c = c;
          w.d = (m == 2'b11) ? gray_m(src0[r][c], 0) : src0[r][c];
          exp_q.push_back(w);
          w.r = r; w.c = c;
          w.d = (m == 2'b11) ? gray_m(src0[H-1-r][c], 0) : src0[H-1-r][c];
          exp_q.push_back(w);
        end
    end
  endtask

  // Compare every dut0 write against the model's expected write sequence.
  always @(negedge clk) begin
    if (if0.write_enable) begin
      wr_cnt++;
      chk("busy_during_write", if0.busy, 1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got write at (%0d,%0d) expected none", if0.row_sel, if0.col_sel);
      end else begin
        e = exp_q.pop_front();
        chk("wr_row", if0.row_sel, e.r);
        chk("wr_col", if0.col_sel, e.c);
        chk("wr_data", if0.pixel_out, e.d);
      end
    end
  end

  task automatic run(input logic [1:0] m, input bit toggle, input string tag);
    int  t0, t1;
    bit  to;
    build_exp(m);
    wr_cnt = 0;
    repeat (2) @(negedge clk);
    if0.start = 1'b1;
    if0.mode  = m;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    if0.start = 1'b0;
    chk({tag, "_busy_rise"}, if0.busy, 1);
    chk({tag, "_done_clear"}, if0.done, 0);
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (toggle) begin
        if0.start = i[0];
        if0.mode  = 2'(i >> 1);
      end
      @(negedge clk);
      if (!if0.busy) begin
        to = 1'b0;
        break;
      end
    end
    if0.start = 1'b0;
    t1 = cyc;
    chk({tag, "_no_timeout"}, to, 0);
    chk({tag, "_cycles"}, t1 - t0, exp_cyc);
    chk({tag, "_done"}, if0.done, 1);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    chk({tag, "_we_count"}, wr_cnt, H * W);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        chk({tag, "_pixel"}, dst0[r][c], exp_img[r][c]);
  endtask

  initial begin
    bit to;
    rst_n = 1'b0;
    if0.start = 1'b0; if0.mode = 2'b00;
    if1.start = 1'b0; if1.mode = 2'b00;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        src0[r][c] = {8'(r), 8'(c), 8'h55};
        src1[r][c] = 24'hFFFFFE;
      end
    repeat (3) @(negedge clk);
    chk("rst_row", if0.row_sel, 0);
    chk("rst_col", if0.col_sel, 0);
    chk("rst_we", if0.write_enable, 0);
    chk("rst_pix", if0.pixel_out, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    rst_n = 1'b1;

    // hmirror with start/mode toggling while busy
    run(2'b01, 1'b1, "hs_hmirror");
    chk("hs_lit_1_0", dst0[1][0], 24'h010355);

    run(2'b00, 1'b0, "vmirror");
    chk("vm_lit_0_0", dst0[0][0], 24'h030055);
    chk("vm_lit_3_2", dst0[3][2], 24'h000255);
    chk("vm_cycles_lit", exp_cyc, 40);

    run(2'b01, 1'b0, "hmirror");
    chk("hm_lit_2_1", dst0[2][1], 24'h020255);

    src0[1][2] = 24'h3C8010;
    run(2'b10, 1'b0, "gray");
    chk("gray_lit_1_2", dst0[1][2], 24'h004800);
    chk("gray_lit_0_0", dst0[0][0], 24'h002A00);

    run(2'b11, 1'b0, "vgray");
    chk("vg_lit_2_2", dst0[2][2], 24'h004800);
    chk("vg_lit_0_0", dst0[0][0], 24'h002A00);
    chk("vg_cycles_lit", exp_cyc, 48);

    // reset in the middle of a transform
    build_exp(2'b00);
    repeat (2) @(negedge clk);
    if0.start = 1'b1; if0.mode = 2'b00;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_we", if0.write_enable, 0);
    chk("midrst_busy", if0.busy, 0);
    chk("midrst_done", if0.done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_busy", if0.busy, 0);
    run(2'b00, 1'b0, "restart");

    // replicated gray on the second instance
    @(negedge clk);
    if1.start = 1'b1; if1.mode = 2'b10;
    @(negedge clk);
    if1.start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!if1.busy) begin
        to = 1'b0;
        break;
      end
    end
    chk("rep_no_timeout", to, 0);
    chk("rep_done", if1.done, 1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        chk("rep_pixel", dst1[r][c], 24'hFEFEFE);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
